// File: rtl/calltrace_pkg.sv
// Shared constants and helpers for the hardware call-trace stack.
// IO offsets, status/ctrl bit positions and the status-word packer.
package calltrace_pkg;

    localparam int CTS_DATA = -80;
    localparam int CTS_CTRL = -76;

    localparam int STAT_FROZEN  = 31;
    localparam int STAT_OVFL    = 30;
    localparam int STAT_UNFL    = 29;
    localparam int STAT_AUTOFRZ = 28;
    localparam int STAT_FULL    = 17;
    localparam int STAT_EMPTY   = 16;

    localparam int CTRL_FREEZE  = 0;
    localparam int CTRL_CLEAR   = 1;
    localparam int CTRL_AUTOFRZ = 2;

    localparam int CNT_W  = 9;
    localparam int ADDR_W = 24;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_PUSH,
        OP_POP,
        OP_REPLACE
    } op_t;

    function automatic logic [31:0] pack_status(
        input logic [CNT_W-1:0] cnt,
        input logic             empty,
        input logic             full,
        input logic             autofrz,
        input logic             unfl,
        input logic             ovfl,
        input logic             frozen
    );
        logic [31:0] word;
        word               = '0;
        word[CNT_W-1:0]    = cnt;
        word[STAT_EMPTY]   = empty;
        word[STAT_FULL]    = full;
        word[STAT_AUTOFRZ] = autofrz;
        word[STAT_UNFL]    = unfl;
        word[STAT_OVFL]    = ovfl;
        word[STAT_FROZEN]  = frozen;
        return word;
    endfunction

endpackage

// File: rtl/calltrace_mem.sv
// Link-address storage: synchronous write, asynchronous read.
// Kept free of reset so it maps onto distributed RAM or plain registers.
module calltrace_mem
    import calltrace_pkg::*;
#(
    parameter int depth  = 32,
    parameter int addr_w = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [addr_w-1:0] waddr,
    input  logic [ADDR_W-1:0] wdata,
    input  logic [addr_w-1:0] raddr,
    output logic [ADDR_W-1:0] rdata
);

    logic [ADDR_W-1:0] mem [depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/calltrace.sv
// Call-trace stack IO device: pushes link addresses on BL, pops on return,
// and lets software read back / control the stack through two IO words.
module calltrace
    import calltrace_pkg::*;
#(
    parameter int num_slots = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stb,
    input  logic              we,
    input  logic              addr,
    input  logic [31:0]       data_in,
    output logic [31:0]       data_out,
    output logic              ack,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] call_addr,
    output logic              ovfl
);

    localparam int PTR_W = $clog2(num_slots);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(num_slots);

    logic [PTR_W-1:0]  sp;
    logic [CNT_W-1:0]  cnt;
    logic              frozen;
    logic              unfl;
    logic              autofrz;
    logic              stb_p1;

    logic              first;
    logic              ev_call;
    logic              ev_ret;
    logic              sw_data;
    logic              ctrl_wr;
    logic              empty;
    logic              full;
    logic              set_unfl;
    op_t               op;
    logic [ADDR_W-1:0] push_data;
    logic              mem_we;
    logic [PTR_W-1:0]  mem_waddr;
    logic [PTR_W-1:0]  top_ptr;
    logic [ADDR_W-1:0] top_data;
    logic              unused_data_bits;

    assign unused_data_bits = ^data_in[31:ADDR_W];

    // Side effects fire once per access, on the first stb cycle only.
    assign first    = stb & ~stb_p1;
    assign ev_call  = call & ~frozen;
    assign ev_ret   = ret & ~frozen;
    assign sw_data  = first & ~addr & ~(ev_call | ev_ret);
    assign ctrl_wr  = first & we & addr;
    assign empty    = (cnt == '0);
    assign full     = (cnt == CNT_MAX);
    assign set_unfl = ev_ret & empty;
    assign top_ptr  = sp - PTR_ONE;

    always_comb begin
        op        = OP_NONE;
        push_data = call_addr;
        if (ev_call && ev_ret) begin
            op = empty ? OP_PUSH : OP_REPLACE;
        end else if (ev_call) begin
            op = OP_PUSH;
        end else if (ev_ret) begin
            op = OP_POP;
        end else if (sw_data) begin
            op        = we ? OP_PUSH : OP_POP;
            push_data = data_in[ADDR_W-1:0];
        end
    end

    assign mem_we    = (op == OP_PUSH) || (op == OP_REPLACE);
    assign mem_waddr = (op == OP_REPLACE) ? top_ptr : sp;

    calltrace_mem #(
        .depth  (num_slots),
        .addr_w (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (push_data),
        .raddr (top_ptr),
        .rdata (top_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp      <= '0;
            cnt     <= '0;
            frozen  <= 1'b0;
            ovfl    <= 1'b0;
            unfl    <= 1'b0;
            autofrz <= 1'b0;
            stb_p1  <= 1'b0;
            ack     <= 1'b0;
        end else begin
            stb_p1 <= stb;
            ack    <= first;

            case (op)
                OP_PUSH: begin
                    sp <= sp + PTR_ONE;
                    if (full) begin
                        ovfl <= 1'b1;
                        if (autofrz) begin
                            frozen <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                OP_POP: begin
                    if (!empty) begin
                        sp  <= top_ptr;
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: ;
            endcase

            if (set_unfl) begin
                unfl <= 1'b1;
            end

            // Ctrl writes come last so a clear overrides any same-cycle event.
            if (ctrl_wr) begin
                if (data_in[CTRL_FREEZE]) begin
                    frozen <= 1'b1;
                end
                if (data_in[CTRL_AUTOFRZ]) begin
                    autofrz <= 1'b1;
                end
                if (data_in[CTRL_CLEAR]) begin
                    sp     <= '0;
                    cnt    <= '0;
                    ovfl   <= 1'b0;
                    unfl   <= 1'b0;
                    frozen <= data_in[CTRL_FREEZE];
                end
            end
        end
    end

    always_comb begin
        data_out = '0;
        if (stb) begin
            if (addr) begin
                data_out = pack_status(cnt, empty, full, autofrz, unfl, ovfl, frozen);
            end else if (!empty) begin
                data_out = {{(32-ADDR_W){1'b0}}, top_data};
            end
        end
    end

endmodule

// File: tb/tb_calltrace.sv
// Directed bench for calltrace: a vector table for the basic stack/status
// behaviour, then hand-written sequences for overflow, freeze and timing cases.
module tb_calltrace;

    logic        clk;
    logic        rst_n;
    logic        stb;
    logic        we;
    logic        addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        ack;
    logic        call;
    logic        ret;
    logic [23:0] call_addr;
    logic        ovfl;

    int total  = 0;
    int passed = 0;

    typedef enum {T_CALL, T_RET, T_CALLRET, T_RD_DATA, T_RD_STAT, T_WR_DATA, T_WR_CTRL} top_t;

    typedef struct {
        top_t        op;
        logic [31:0] val;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    calltrace #(.num_slots(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stb       (stb),
        .we        (we),
        .addr      (addr),
        .data_in   (data_in),
        .data_out  (data_out),
        .ack       (ack),
        .call      (call),
        .ret       (ret),
        .call_addr (call_addr),
        .ovfl      (ovfl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish within time budget");
        $fatal(1, "timeout");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic add(input top_t op, input logic [31:0] val, input logic [31:0] exp, input string nm);
        vec_t v;
        v.op = op; v.val = val; v.exp = exp; v.name = nm;
        vecs.push_back(v);
    endtask

    task automatic pulse(input logic c, input logic r, input logic [23:0] a);
        @(negedge clk);
        call = c; ret = r; call_addr = a;
        @(negedge clk);
        call = 1'b0; ret = 1'b0;
    endtask

    // One access held for len cycles, followed by one idle cycle.
    task automatic access(input logic w, input logic a, input logic [31:0] d, input int len,
                          output logic [31:0] rd, output int acks);
        @(negedge clk);
        stb = 1'b1; we = w; addr = a; data_in = d;
        #1 rd = data_out;
        acks = 0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (ack) acks++;
        end
        stb = 1'b0; we = 1'b0; addr = 1'b0;
        @(negedge clk);
        if (ack) acks++;
    endtask

    task automatic rd_stat(input string nm, input logic [31:0] exp);
        logic [31:0] rd;
        int          acks;
        access(1'b0, 1'b1, 32'h0, 1, rd, acks);
        check(nm, rd, exp);
    endtask

    task automatic rd_data(input string nm, input logic [31:0] exp);
        logic [31:0] rd;
        int          acks;
        access(1'b0, 1'b0, 32'h0, 1, rd, acks);
        check(nm, rd, exp);
    endtask

    task automatic wr_ctrl(input logic [31:0] d);
        logic [31:0] rd;
        int          acks;
        access(1'b1, 1'b1, d, 1, rd, acks);
    endtask

    initial begin
        logic [31:0] rd;
        int          acks;

        rst_n = 1'b0; stb = 1'b0; we = 1'b0; addr = 1'b0; data_in = '0;
        call = 1'b0; ret = 1'b0; call_addr = '0;
        check("reset_ack", {31'b0, ack}, 32'h0);
        check("reset_ovfl", {31'b0, ovfl}, 32'h0);
        check("reset_data_out_idle", data_out, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        add(T_RD_STAT, 0, 32'h0001_0000, "rst_status");
        add(T_RD_DATA, 0, 32'h0000_0000, "rst_data_empty");
        add(T_RD_STAT, 0, 32'h0001_0000, "empty_read_no_unfl");
        add(T_CALL, 32'h100, 0, "");
        add(T_CALL, 32'h200, 0, "");
        add(T_CALL, 32'h300, 0, "");
        add(T_RET, 0, 0, "");
        add(T_RD_STAT, 0, 32'h0000_0002, "cnt2_after_ret");
        add(T_RD_DATA, 0, 32'h0000_0200, "top_0200");
        add(T_RD_STAT, 0, 32'h0000_0001, "cnt1_after_pop");
        add(T_RD_DATA, 0, 32'h0000_0100, "top_0100");
        add(T_RD_STAT, 0, 32'h0001_0000, "empty_again");
        add(T_RET, 0, 0, "");
        add(T_RD_STAT, 0, 32'h2001_0000, "unfl_on_empty_ret");
        add(T_WR_CTRL, 32'h2, 0, "");
        add(T_RD_STAT, 0, 32'h0001_0000, "clear_status");
        add(T_CALL, 32'h100, 0, "");
        add(T_CALLRET, 32'hABC, 0, "");
        add(T_RD_STAT, 0, 32'h0000_0001, "callret_cnt");
        add(T_RD_DATA, 0, 32'h0000_0ABC, "callret_replaced");
        add(T_CALLRET, 32'h555, 0, "");
        add(T_RD_STAT, 0, 32'h2000_0001, "callret_empty_push_unfl");
        add(T_RD_DATA, 0, 32'h0000_0555, "callret_empty_top");
        add(T_WR_DATA, 32'hFFAB_CDEF, 0, "");
        add(T_RD_STAT, 0, 32'h2000_0001, "sw_push_cnt");
        add(T_RD_DATA, 0, 32'h00AB_CDEF, "sw_push_top");
        add(T_WR_CTRL, 32'h3, 0, "");
        add(T_RD_STAT, 0, 32'h8001_0000, "clear_and_freeze");
        add(T_CALL, 32'h777, 0, "");
        add(T_RET, 0, 0, "");
        add(T_RD_STAT, 0, 32'h8001_0000, "frozen_ignores_events");
        add(T_WR_CTRL, 32'h2, 0, "");
        add(T_RD_STAT, 0, 32'h0001_0000, "clear_unfreezes");

        foreach (vecs[i]) begin
            case (vecs[i].op)
                T_CALL:    pulse(1'b1, 1'b0, vecs[i].val[23:0]);
                T_RET:     pulse(1'b0, 1'b1, 24'h0);
                T_CALLRET: pulse(1'b1, 1'b1, vecs[i].val[23:0]);
                T_RD_DATA, T_RD_STAT: begin
                    access(1'b0, vecs[i].op == T_RD_STAT, 32'h0, 1, rd, acks);
                    check(vecs[i].name, rd, vecs[i].exp);
                    check({vecs[i].name, "_ack"}, acks, 32'd1);
                end
                T_WR_DATA, T_WR_CTRL: begin
                    access(1'b1, vecs[i].op == T_WR_CTRL, vecs[i].val, 1, rd, acks);
                    check("write_ack", acks, 32'd1);
                end
                default: ;
            endcase
        end

        // stb held for three cycles: one pop, one ack pulse.
        pulse(1'b1, 1'b0, 24'h000011);
        pulse(1'b1, 1'b0, 24'h000022);
        access(1'b0, 1'b0, 32'h0, 3, rd, acks);
        check("held_read_data", rd, 32'h0000_0022);
        check("held_read_ack_count", acks, 32'd1);
        rd_stat("held_read_single_pop", 32'h0000_0001);

        // Data write coinciding with a call: the call wins, the write is dropped.
        @(negedge clk);
        stb = 1'b1; we = 1'b1; addr = 1'b0; data_in = 32'h0000_0099;
        call = 1'b1; call_addr = 24'h000033;
        @(negedge clk);
        call = 1'b0;
        check("collide_ack", {31'b0, ack}, 32'h1);
        stb = 1'b0; we = 1'b0;
        @(negedge clk);
        rd_stat("collide_cnt", 32'h0000_0002);
        rd_data("collide_top_is_call", 32'h0000_0033);
        rd_data("collide_below", 32'h0000_0011);

        // 33 calls into 32 slots: oldest overwritten, ovfl sticky.
        wr_ctrl(32'h2);
        for (int i = 1; i <= 33; i++) pulse(1'b1, 1'b0, 24'(i));
        rd_stat("overflow_status", 32'h4002_0020);
        check("overflow_led", {31'b0, ovfl}, 32'h1);
        for (int i = 33; i >= 2; i--) rd_data($sformatf("drain_%0d", i), 32'(i));
        rd_stat("drained_empty_ovfl_kept", 32'h4001_0000);

        // Auto-freeze on overflow.
        wr_ctrl(32'h2);
        wr_ctrl(32'h4);
        for (int i = 1; i <= 32; i++) pulse(1'b1, 1'b0, 24'(i + 100));
        rd_stat("autofrz_full_not_frozen", 32'h1002_0020);
        pulse(1'b1, 1'b0, 24'd133);
        rd_stat("autofrz_frozen", 32'hD002_0020);
        pulse(1'b1, 1'b0, 24'd200);
        pulse(1'b0, 1'b1, 24'd0);
        pulse(1'b1, 1'b1, 24'd201);
        rd_stat("autofrz_events_ignored", 32'hD002_0020);
        wr_ctrl(32'h2);
        rd_stat("clear_keeps_autofrz", 32'h1001_0000);

        // Asynchronous reset mid-operation.
        pulse(1'b1, 1'b0, 24'h000044);
        for (int i = 0; i < 32; i++) pulse(1'b1, 1'b0, 24'h000045);
        check("pre_reset_ovfl", {31'b0, ovfl}, 32'h1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_ovfl", {31'b0, ovfl}, 32'h0);
        stb = 1'b1; addr = 1'b1;
        #1;
        check("async_reset_status", data_out, 32'h0001_0000);
        stb = 1'b0; addr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rd_stat("post_reset_status", 32'h0001_0000);
        rd_data("post_reset_data", 32'h0000_0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/calltrace.md
# calltrace

Hardware call-trace stack for the RISC5 environment: records the link address of every procedure call the CPU makes and discards it on return, so the most recent call chain survives a trap or hang for post-mortem readout. It is an IO device on the 64-word IO block, with data at -80 and ctrl/status at -76. Call/return events come directly from the RISC5 core; the software side uses the same stb/we/addr/data_in/data_out/ack device protocol as the other IO devices.

## Interface
Parameters:
- num_slots, 32, stack depth in entries; power of two, 4..256.

Ports (clock and reset: one clock; reset is asynchronous and active-low):
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- stb  in  1  device select; high while the CPU addresses -80 or -76.
- we  in  1  write when high, read when low.
- addr  in  1  adr[2]: 0 = data, 1 = ctrl/status.
- data_in  in  32  CPU write data.
- data_out  out  32  read data, combinational from current state.
- ack  out  1  access acknowledge.
- call  in  1  one-cycle pulse: the CPU executed a BL.
- ret  in  1  one-cycle pulse: the CPU executed a return (B LNK).
- call_addr  in  24  link address that accompanies call.
- ovfl  out  1  sticky overflow flag, for an LED.

## Operation
- State:
  - sp: log2(num_slots) bits; next free slot.
  - cnt: 0..num_slots, 9 bits.
  - Flags: frozen, ovfl, unfl, autofrz.
  - mem: num_slots x 24; not reset.
- Hardware events are ignored while frozen.
- call only:
  - mem[sp] <= call_addr; sp <= sp+1 (wraps mod num_slots).
  - If cnt == num_slots: cnt stays, the oldest entry is overwritten, and ovfl <= 1. Otherwise cnt <= cnt+1.
  - If the push sets ovfl and autofrz == 1: frozen <= 1 in the same edge.
- ret only:
  - cnt > 0: sp <= sp-1; cnt <= cnt-1.
  - cnt == 0: no change except unfl <= 1.
- call and ret together:
  - cnt > 0: mem[sp-1] <= call_addr; sp and cnt unchanged.
  - cnt == 0: treated as a plain call, and unfl <= 1.
- Software access side effects occur once per access, in the first stb cycle (stb & ~stb_q).
- Data read (addr 0):
  - data_out = {8'h0, mem[sp-1]} if cnt > 0, else 0.
  - Pops one entry as ret does, but never sets unfl.
- Data write (addr 0): pushes data_in[23:0] as call does.
- When not frozen and a data access coincides with a call/ret:
  - The hardware event wins and the data access side effect is dropped.
  - data_out is still valid.
- Status read (addr 1), data_out bits:
  - [8:0] cnt
  - [16] empty
  - [17] full
  - [28] autofrz
  - [29] unfl
  - [30] ovfl
  - [31] frozen
  - all other bits 0
- Ctrl write (addr 1), data_in bits:
  - [0] sets frozen.
  - [1] clear: sp, cnt, ovfl, unfl <= 0; frozen is then taken from bit 0.
  - [2] sets autofrz.
  - Ctrl writes apply regardless of frozen, and clear overrides any same-cycle event.

## Timing
- Reset values: sp=0, cnt=0, all flags 0, ack=0, ovfl=0, data_out=0 when idle or empty.
- data_out is combinational; the CPU samples it in the stb cycle, before the pop edge.
- ack: registered, high for exactly one cycle, in the cycle after the first stb cycle.
  - Access lengths: single-cycle or stalled.
- A stb held for N cycles causes one side effect and one ack pulse; a new access requires stb low for at least one cycle.
- call/ret effects are visible in status one cycle after the pulse.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous); mem content is retained but unreachable because cnt=0.

## Structure
- Shared package/include holds:
  - IO offsets: CTS_DATA = -80, CTS_CTRL = -76.
  - Status bit positions: STAT_FROZEN=31, STAT_OVFL=30, STAT_UNFL=29, STAT_AUTOFRZ=28, STAT_FULL=17, STAT_EMPTY=16.
  - Ctrl bit positions: CTRL_FREEZE=0, CTRL_CLEAR=1, CTRL_AUTOFRZ=2.
- One sub-module, calltrace_mem:
  - Inputs: clk, we, waddr, wdata, raddr.
  - Output: rdata.
  - Write is synchronous, read is asynchronous, 24 bits wide; it infers distributed RAM or registers.
- Top integration:
  - cts_stb = io_en && adr[7:3] == 5'b10110.
  - The data_out multiplexer gets a cts entry.

## Test plan
- Reset, then read status -> 32'h0001_0000 (empty); read data -> 0; ack pulses once.
- call with call_addr 24'h000100, 24'h000200, 24'h000300, then one ret -> status cnt=2; data read -> 32'h0000_0200, then cnt=1.
- 33 calls with addresses 1..33, num_slots=32 -> cnt=32, ovfl=1, full=1; 32 data reads return 33 down to 2, then empty.
- Ctrl write 32'h4, then 33 calls -> frozen=1 after call 33; further call/ret leave cnt=32.
- ret with cnt=0 -> unfl=1, cnt=0; ctrl write 32'h2 -> status 32'h0001_0000.
- call and ret in the same cycle with cnt=1, top=24'h000100, call_addr 24'h000ABC -> cnt=1, data read 32'h0000_0ABC.
- stb held 3 cycles on a data read with cnt=2 -> one pop (cnt=1), one ack pulse.
